// File: rtl/adc_current_sampler_pkg.sv
// Shared types and constants for the phase-current ADC sampler.
//   adc_smp_state_t : top-level sequencing states
//   ADC_FRAME_BITS  : bits per SPI frame (16)
package adc_current_sampler_pkg;

  localparam int ADC_FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_GAP,
    DONE
  } adc_smp_state_t;

endpackage

// File: rtl/adc_spi_frame.sv
// One 16-bit CPOL=0 SPI transfer: a setup half-period with SCLK low, then 16
// SCLK periods (low half, high half), each half SCLK_DIV clk cycles long.
//   clk, rst  : system clock, synchronous active-high reset
//   start     : 1-cycle pulse, loads tx_word and begins the setup half-period
//   tx_word   : word shifted out on mosi, MSB first
//   sclk      : SPI clock (idle low)
//   mosi      : changes on the clk that drives sclk low
//   miso      : sampled on the clk that drives sclk high
//   rx_word   : received word, MSB first; complete when done is high
//   done      : high in the last cycle of the transfer (combinational)
module adc_spi_frame
  import adc_current_sampler_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADC_FRAME_BITS-1:0] tx_word,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [ADC_FRAME_BITS-1:0] rx_word,
  output logic                      done
);

  localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);
  // Half-periods remaining after the current one: setup + 2 per bit.
  localparam logic [5:0]       PH_FIRST = 6'(2 * ADC_FRAME_BITS);

  logic                      active;
  logic [5:0]                ph_left;
  logic [5:0]                ph_nxt;
  logic [DIV_W-1:0]          div_cnt;
  logic [ADC_FRAME_BITS-1:0] tx_sh;
  logic [ADC_FRAME_BITS-1:0] rx_sh;
  logic                      ph_end;

  assign ph_end  = active && (div_cnt == '0);
  assign ph_nxt  = ph_left - 6'd1;
  assign done    = ph_end && (ph_left == '0);
  assign mosi    = active & tx_sh[ADC_FRAME_BITS-1];
  assign rx_word = rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      ph_left <= '0;
      div_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else if (start) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      ph_left <= PH_FIRST;
      div_cnt <= DIV_LOAD;
      tx_sh   <= tx_word;
    end else if (ph_end) begin
      div_cnt <= DIV_LOAD;
      if (ph_left == '0) begin
        active <= 1'b0;
        sclk   <= 1'b0;
      end else begin
        ph_left <= ph_nxt;
        // Odd remaining count = low half. The first low half keeps the MSB
        // already presented during setup, later ones advance the word.
        if (ph_nxt[0]) begin
          sclk <= 1'b0;
          if (ph_nxt != PH_FIRST - 6'd1) tx_sh <= tx_sh << 1;
        end else begin
          sclk  <= 1'b1;
          rx_sh <= {rx_sh[ADC_FRAME_BITS-2:0], miso};
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/adc_current_sampler.sv
// SPI master for the phase-current ADC. On an accepted trigger it reads ADC_N
// channels in sequence (one 16-bit frame each), subtracts per-channel offsets
// and presents signed currents together with a 1-cycle cur_vld strobe.
//   clk, rst : system clock, synchronous active-high reset
//   en       : enables trigger acceptance (a running sequence always completes)
//   trig     : 1-cycle start strobe
//   offset   : per-channel zero-current code, sampled only in DONE
//   adc_*    : SPI pins (CPOL=0, active-low CS)
//   cur      : signed raw - offset per channel, held between strobes
//   cur_vld  : 1-cycle strobe, cur[] is new in this cycle
//   busy     : from trigger acceptance through the cur_vld cycle
//   ovr      : 1-cycle strobe, a trigger arrived while busy and was dropped
//
// state    | meaning
// IDLE     | waiting for trig & en
// CS_SETUP | CS low, SCLK low, MOSI shows the word MSB
// SHIFT    | 16 SCLK periods of the current frame
// CS_GAP   | CS high for CS_HIGH cycles between frames
// DONE     | offset subtraction, cur_vld follows on the next cycle
module adc_current_sampler
  import adc_current_sampler_pkg::*;
#(
  parameter int ADC_N    = 2,
  parameter int ADC_W    = 12,
  parameter int SCLK_DIV = 2,
  parameter int CS_HIGH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        trig,
  input  logic [ADC_N-1:0][ADC_W-1:0] offset,
  output logic                        adc_sclk,
  output logic                        adc_cs,
  output logic                        adc_mosi,
  input  logic                        adc_miso,
  output logic [ADC_N-1:0][ADC_W:0]   cur,
  output logic                        cur_vld,
  output logic                        busy,
  output logic                        ovr
);

  localparam int               TMR_MAX    = (SCLK_DIV > CS_HIGH) ? SCLK_DIV : CS_HIGH;
  localparam int               TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(CS_HIGH - 1);
  localparam logic [1:0]       CH_LAST    = 2'(ADC_N - 1);

  adc_smp_state_t              state, state_nxt;
  logic [1:0]                  ch, ch_nxt;
  logic [TMR_W-1:0]            tmr, tmr_nxt;
  logic                        tmr_tc;
  logic                        accept;
  logic                        frm_start;
  logic                        frm_done;
  logic [ADC_FRAME_BITS-1:0]   tx_word;
  logic [ADC_FRAME_BITS-1:0]   rx_word;
  logic [ADC_N-1:0][ADC_W-1:0] raw;
  logic                        unused_rx;

  assign tmr_tc    = (tmr == '0);
  // The cur_vld cycle still counts as busy, so a trigger there is dropped.
  assign busy      = (state != IDLE) | cur_vld;
  assign accept    = trig & en & ~busy;
  assign adc_cs    = ~((state == CS_SETUP) | (state == SHIFT));
  // The word selects the channel converted in the frame being started.
  assign tx_word   = {2'b00, ch_nxt, {(ADC_FRAME_BITS-4){1'b0}}};
  assign unused_rx = ^rx_word;

  adc_spi_frame #(
    .SCLK_DIV (SCLK_DIV)
  ) u_frame (
    .clk     (clk),
    .rst     (rst),
    .start   (frm_start),
    .tx_word (tx_word),
    .sclk    (adc_sclk),
    .mosi    (adc_mosi),
    .miso    (adc_miso),
    .rx_word (rx_word),
    .done    (frm_done)
  );

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    tmr_nxt   = tmr_tc ? tmr : tmr - 1'b1;
    frm_start = 1'b0;
    case (state)
      IDLE: begin
        ch_nxt = '0;
        if (accept) begin
          state_nxt = CS_SETUP;
          tmr_nxt   = SETUP_LOAD;
          frm_start = 1'b1;
        end
      end
      CS_SETUP: begin
        if (tmr_tc) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (frm_done) begin
          state_nxt = CS_GAP;
          tmr_nxt   = GAP_LOAD;
        end
      end
      CS_GAP: begin
        if (tmr_tc) begin
          if (ch == CH_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CS_SETUP;
            ch_nxt    = ch + 2'd1;
            tmr_nxt   = SETUP_LOAD;
            frm_start = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ch_nxt    = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      tmr     <= '0;
      raw     <= '0;
      cur     <= '0;
      cur_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      tmr     <= tmr_nxt;
      cur_vld <= (state == DONE);
      ovr     <= trig & busy;
      if ((state == SHIFT) && frm_done) begin
        for (int k = 0; k < ADC_N; k++) begin
          if (ch == 2'(k)) raw[k] <= rx_word[ADC_W-1:0];
        end
      end
      if (state == DONE) begin
        for (int k = 0; k < ADC_N; k++) begin
          cur[k] <= $signed({1'b0, raw[k]}) - $signed({1'b0, offset[k]});
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_current_sampler.sv
// Self-checking bench for adc_current_sampler (ADC_N=2, ADC_W=12, SCLK_DIV=2,
// CS_HIGH=4). A behavioural ADC model answers each CS-low frame with a preset
// 16-bit word, shifting a new bit out after every SCLK fall, and records the
// MOSI word and SCLK rise count per frame.
module tb_adc_current_sampler;

  localparam int LAT = 1 + 2 * (2 + 64 + 4) + 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             trig;
  logic [1:0][11:0] offset;
  logic             adc_sclk;
  logic             adc_cs;
  logic             adc_mosi;
  logic             adc_miso;
  logic [1:0][12:0] cur;
  logic             cur_vld;
  logic             busy;
  logic             ovr;

  int checks = 0;
  int errors = 0;

  adc_current_sampler #(
    .ADC_N    (2),
    .ADC_W    (12),
    .SCLK_DIV (2),
    .CS_HIGH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .trig     (trig),
    .offset   (offset),
    .adc_sclk (adc_sclk),
    .adc_cs   (adc_cs),
    .adc_mosi (adc_mosi),
    .adc_miso (adc_miso),
    .cur      (cur),
    .cur_vld  (cur_vld),
    .busy     (busy),
    .ovr      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ADC model ----------------
  logic [15:0] mdl_data [4];
  logic [15:0] mdl_mosi [4];
  int          mdl_rises [4];
  int          mdl_frames;
  int          mdl_sclk_bad;
  logic        mdl_clr = 1'b0;
  logic [15:0] mdl_word;
  int          mdl_bit;
  int          mdl_rcnt;
  logic [15:0] mdl_rx;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  initial adc_miso = 1'b0;

  always @(negedge clk) begin
    if (rst || mdl_clr) begin
      mdl_frames   = 0;
      mdl_sclk_bad = 0;
      mdl_bit      = 15;
      mdl_rcnt     = 0;
      mdl_rx       = '0;
      mdl_word     = '0;
      adc_miso     = 1'b0;
      for (int i = 0; i < 4; i++) begin
        mdl_rises[i] = 0;
        mdl_mosi[i]  = 16'hFFFF;
      end
    end else begin
      if (adc_cs && adc_sclk) mdl_sclk_bad++;
      if (prev_cs && !adc_cs) begin
        mdl_word = mdl_data[mdl_frames[1:0]];
        mdl_bit  = 15;
        adc_miso = mdl_word[15];
        mdl_rcnt = 0;
        mdl_rx   = '0;
      end else if (!adc_cs && prev_sclk && !adc_sclk) begin
        if (mdl_bit > 0) mdl_bit--;
        adc_miso = mdl_word[mdl_bit];
      end
      if (!adc_cs && !prev_sclk && adc_sclk) begin
        mdl_rx = {mdl_rx[14:0], adc_mosi};
        mdl_rcnt++;
      end
      if (!prev_cs && adc_cs) begin
        if (mdl_frames < 4) begin
          mdl_rises[mdl_frames] = mdl_rcnt;
          mdl_mosi[mdl_frames]  = mdl_rx;
        end
        mdl_frames++;
      end
    end
    prev_cs   = adc_cs;
    prev_sclk = adc_sclk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full sequence. ovr_at / en_drop_at give the cycle (trigger cycle = 0)
  // of an extra trigger / of en falling; 0 disables. chg alters the offsets
  // mid-sequence, the values present at the end must be the ones used.
  task automatic run_seq(input string name, input logic [11:0] d0, input logic [11:0] d1,
                         input logic [11:0] o0, input logic [11:0] o1,
                         input int ovr_at, input int en_drop_at, input bit chg);
    int vld_cyc, vld_cnt, ovr_cyc, ovr_cnt, busy_bad;
    int exp0, exp1, got0, got1, exp_ovr;
    logic [11:0] eo0, eo1;
    mdl_data[0] = {4'($urandom), d0};
    mdl_data[1] = {4'($urandom), d1};
    offset[0] = o0;
    offset[1] = o1;
    eo0 = chg ? (o0 ^ 12'hA5A) : o0;
    eo1 = chg ? (o1 ^ 12'h5A5) : o1;
    en = 1'b1;
    mdl_clr = 1'b1;
    tick;
    mdl_clr = 1'b0;
    trig = 1'b1;
    tick;
    trig = 1'b0;
    checks++;
    if (adc_cs !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start: cs=%b busy=%b, want cs=0 busy=1", name, adc_cs, busy);
    end
    vld_cyc = -1; vld_cnt = 0; ovr_cyc = -1; ovr_cnt = 0; busy_bad = 0;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      trig = (cyc == ovr_at);
      if (cyc == en_drop_at) en = 1'b0;
      if (chg && cyc == 60) begin
        offset[0] = eo0;
        offset[1] = eo1;
      end
      if (cur_vld === 1'b1) begin
        vld_cnt++;
        if (vld_cyc < 0) vld_cyc = cyc;
      end
      if (ovr === 1'b1) begin
        ovr_cnt++;
        if (ovr_cyc < 0) ovr_cyc = cyc;
      end
      if (busy !== (cyc <= LAT)) busy_bad++;
      tick;
    end
    trig = 1'b0;
    en = 1'b1;

    checks++;
    if (vld_cyc != LAT || vld_cnt != 1) begin
      errors++;
      $display("FAIL %s latency: cur_vld at %0d (%0d pulses), want %0d (1 pulse)", name, vld_cyc, vld_cnt, LAT);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy: %0d wrong cycles, want 0", name, busy_bad);
    end
    exp_ovr = (ovr_at > 0) ? 1 : 0;
    checks++;
    if (ovr_cnt != exp_ovr || (exp_ovr == 1 && ovr_cyc != ovr_at + 1)) begin
      errors++;
      $display("FAIL %s ovr: %0d pulses at %0d, want %0d at %0d", name, ovr_cnt, ovr_cyc, exp_ovr, ovr_at + 1);
    end
    exp0 = int'(d0) - int'(eo0);
    exp1 = int'(d1) - int'(eo1);
    got0 = int'($signed(cur[0]));
    got1 = int'($signed(cur[1]));
    checks++;
    if (got0 != exp0) begin
      errors++;
      $display("FAIL %s cur0: got %0d, want %0d", name, got0, exp0);
    end
    checks++;
    if (got1 != exp1) begin
      errors++;
      $display("FAIL %s cur1: got %0d, want %0d", name, got1, exp1);
    end
    checks++;
    if (mdl_frames != 2 || mdl_rises[0] != 16 || mdl_rises[1] != 16) begin
      errors++;
      $display("FAIL %s frames: %0d frames, rises %0d/%0d, want 2 frames, 16/16", name, mdl_frames, mdl_rises[0], mdl_rises[1]);
    end
    checks++;
    if (mdl_mosi[0] !== 16'h0000 || mdl_mosi[1] !== 16'h1000) begin
      errors++;
      $display("FAIL %s mosi: %h/%h, want 0000/1000", name, mdl_mosi[0], mdl_mosi[1]);
    end
    checks++;
    if (mdl_sclk_bad != 0) begin
      errors++;
      $display("FAIL %s sclk_cs: sclk high with cs high %0d times, want 0", name, mdl_sclk_bad);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    checks++;
    if (adc_cs !== 1'b1 || adc_sclk !== 1'b0 || adc_mosi !== 1'b0) begin
      errors++;
      $display("FAIL reset pins: cs=%b sclk=%b mosi=%b, want 1 0 0", adc_cs, adc_sclk, adc_mosi);
    end
    checks++;
    if (busy !== 1'b0 || cur_vld !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: busy=%b vld=%b ovr=%b, want 0 0 0", busy, cur_vld, ovr);
    end
    checks++;
    if (cur !== 26'h0) begin
      errors++;
      $display("FAIL reset cur: got %h, want 0", cur);
    end
  endtask

  task automatic test_directed;
    run_seq("mid", 12'h800, 12'h7FF, 12'h800, 12'h800, 0, 0, 1'b0);
    checks++;
    if (cur[1] !== 13'h1FFF) begin
      errors++;
      $display("FAIL mid cur1 bits: got %h, want 1fff", cur[1]);
    end
    run_seq("ends", 12'hFFF, 12'h000, 12'h800, 12'h800, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      run_seq("rand", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 0, 0, (i % 2) == 1);
    end
  endtask

  task automatic test_back_to_back;
    run_seq("ovr50", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 50, 0, 1'b0);
    run_seq("ovr_done", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), LAT - 1, 0, 1'b0);
    run_seq("after_ovr", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 0, 0, 1'b0);
  endtask

  task automatic test_enable;
    int cs_low, ovr_cnt, busy_cnt;
    run_seq("en_drop", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 0, 100, 1'b0);
    en = 1'b0;
    trig = 1'b1;
    tick;
    trig = 1'b0;
    cs_low = 0; ovr_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (adc_cs !== 1'b1) cs_low++;
      if (ovr !== 1'b0) ovr_cnt++;
      if (busy !== 1'b0) busy_cnt++;
      tick;
    end
    en = 1'b1;
    checks++;
    if (cs_low != 0 || ovr_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL en_off: cs_low=%0d ovr=%0d busy=%0d cycles, want 0 0 0", cs_low, ovr_cnt, busy_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int vld_cnt, cs_low;
    en = 1'b1;
    mdl_clr = 1'b1;
    tick;
    mdl_clr = 1'b0;
    trig = 1'b1;
    tick;
    trig = 1'b0;
    repeat (19) tick;
    checks++;
    if (adc_cs !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid pre: cs=%b, want 0", adc_cs);
    end
    rst = 1'b1;
    tick;
    checks++;
    if (adc_cs !== 1'b1 || adc_sclk !== 1'b0 || busy !== 1'b0 || cur_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid pins: cs=%b sclk=%b busy=%b vld=%b, want 1 0 0 0", adc_cs, adc_sclk, busy, cur_vld);
    end
    checks++;
    if (cur !== 26'h0) begin
      errors++;
      $display("FAIL rst_mid cur: got %h, want 0", cur);
    end
    rst = 1'b0;
    vld_cnt = 0; cs_low = 0;
    for (int c = 0; c < 160; c++) begin
      if (cur_vld === 1'b1) vld_cnt++;
      if (adc_cs !== 1'b1) cs_low++;
      tick;
    end
    checks++;
    if (vld_cnt != 0 || cs_low != 0 || cur !== 26'h0) begin
      errors++;
      $display("FAIL rst_mid after: vld=%0d cs_low=%0d cur=%h, want 0 0 0", vld_cnt, cs_low, cur);
    end
    run_seq("post_rst", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    trig = 1'b0;
    offset = '0;
    for (int i = 0; i < 4; i++) mdl_data[i] = '0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
